// File: rtl/wb_stage_pipe.sv
// Write-back stage: arbitrates NSRC producers into a one-cycle WB register that drives the RF write port.
// Define WB_TRACE_EN to drive the difftest trace outputs; otherwise they are tied to zero.
module wb_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int ARB_RR = 0,
    parameter int CNT_W  = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NSRC-1:0]                       src_valid,
    input  logic [NSRC*(1+REG_AW+2*DATA_W)-1:0]   src_bus,
    output logic [NSRC-1:0]                       src_ready,
    input  logic                                  ws_flush,
    output logic                                  ws_to_rf_valid,
    output logic [REG_AW+DATA_W:0]                ws_to_rf_bus,
    output logic [CNT_W-1:0]                      ws_retire_cnt,
    output logic [DATA_W-1:0]                     debug_wb_pc,
    output logic [3:0]                            debug_wb_rf_we,
    output logic [REG_AW-1:0]                     debug_wb_rf_wnum,
    output logic [DATA_W-1:0]                     debug_wb_rf_wdata
);
    localparam int BUS_W = 1 + REG_AW + 2*DATA_W;
    localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]   grant;
    logic [NSRC-1:0]   xfer;
    logic              take;
    logic [BUS_W-1:0]  sel_bus;
    logic              ws_valid;
    logic [BUS_W-1:0]  ws_bus_r;
    logic              gr_we;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] result;
    logic              rf_we;

    generate
        if (ARB_RR != 0) begin : g_rr
            logic [PTR_W-1:0] rr_ptr;
            logic [PTR_W-1:0] ptr_nxt;
            logic             found;

            // Search order starts at rr_ptr and wraps; idle ready parks on rr_ptr.
            always_comb begin
                grant = '0;
                found = 1'b0;
                for (int k = 0; k < NSRC; k++) begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (!found && (i == (int'(rr_ptr) + k) % NSRC) && src_valid[i]) begin
                            grant[i] = 1'b1;
                            found    = 1'b1;
                        end
                    end
                end
                if (!found) begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (i == int'(rr_ptr)) grant[i] = 1'b1;
                    end
                end
            end

            always_comb begin
                ptr_nxt = rr_ptr;
                for (int i = 0; i < NSRC; i++) begin
                    if (xfer[i]) ptr_nxt = PTR_W'((i + 1) % NSRC);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) rr_ptr <= '0;
                else if (take) rr_ptr <= ptr_nxt;
            end
        end else begin : g_fixed
            // Ready is an allowin: it ignores the channel's own valid.
            always_comb begin
                grant = '0;
                for (int i = 0; i < NSRC; i++) begin
                    grant[i] = 1'b1;
                    for (int j = 0; j < i; j++) begin
                        if (src_valid[j]) grant[i] = 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign src_ready = ws_flush ? '0 : grant;
    assign xfer      = src_valid & src_ready;
    assign take      = |xfer;

    always_comb begin
        sel_bus = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (xfer[i]) sel_bus = src_bus[i*BUS_W +: BUS_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid      <= 1'b0;
            ws_bus_r      <= '0;
            ws_retire_cnt <= '0;
        end else begin
            ws_valid <= take;
            if (take) ws_bus_r <= sel_bus;
            if (ws_valid) ws_retire_cnt <= ws_retire_cnt + CNT_W'(1);
        end
    end

    assign gr_we  = ws_bus_r[BUS_W-1];
    assign dest   = ws_bus_r[2*DATA_W +: REG_AW];
    assign result = ws_bus_r[DATA_W +: DATA_W];
    assign rf_we  = ws_valid & gr_we & (|dest);

    assign ws_to_rf_valid = ws_valid;
    assign ws_to_rf_bus   = {rf_we, dest, result};

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = ws_bus_r[DATA_W-1:0];
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest;
    assign debug_wb_rf_wdata = result;
`else
    logic unused_pc;
    assign unused_pc         = ^ws_bus_r[DATA_W-1:0];
    assign debug_wb_pc       = '0;
    assign debug_wb_rf_we    = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: fixed-priority, round-robin and 4-bit-counter instances share one stimulus.
module tb_wb_stage_pipe;
    localparam int BUS_W = 70;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
    } inst_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_valid;
    logic        flush;
    inst_t       chan [2];
    logic [2*BUS_W-1:0] src_bus;
    assign src_bus = {chan[1], chan[0]};

    logic [1:0]  rdy [3];
    logic        rfv [3];
    logic [37:0] rfb [3];
    logic [31:0] cnt [3];
    logic [3:0]  cnt_w4;
    logic [31:0] dpc [3];
    logic [3:0]  dwe [3];
    logic [4:0]  dwn [3];
    logic [31:0] dwd [3];
    assign cnt[2] = {28'd0, cnt_w4};

    always #5 clk = ~clk;

    wb_stage_pipe #(.ARB_RR(0)) u_fp (
        .clk(clk), .reset(reset), .src_valid(s_valid), .src_bus(src_bus), .src_ready(rdy[0]),
        .ws_flush(flush), .ws_to_rf_valid(rfv[0]), .ws_to_rf_bus(rfb[0]), .ws_retire_cnt(cnt[0]),
        .debug_wb_pc(dpc[0]), .debug_wb_rf_we(dwe[0]), .debug_wb_rf_wnum(dwn[0]), .debug_wb_rf_wdata(dwd[0]));

    wb_stage_pipe #(.ARB_RR(1)) u_rr (
        .clk(clk), .reset(reset), .src_valid(s_valid), .src_bus(src_bus), .src_ready(rdy[1]),
        .ws_flush(flush), .ws_to_rf_valid(rfv[1]), .ws_to_rf_bus(rfb[1]), .ws_retire_cnt(cnt[1]),
        .debug_wb_pc(dpc[1]), .debug_wb_rf_we(dwe[1]), .debug_wb_rf_wnum(dwn[1]), .debug_wb_rf_wdata(dwd[1]));

    wb_stage_pipe #(.ARB_RR(0), .CNT_W(4)) u_w4 (
        .clk(clk), .reset(reset), .src_valid(s_valid), .src_bus(src_bus), .src_ready(rdy[2]),
        .ws_flush(flush), .ws_to_rf_valid(rfv[2]), .ws_to_rf_bus(rfb[2]), .ws_retire_cnt(cnt_w4),
        .debug_wb_pc(dpc[2]), .debug_wb_rf_we(dwe[2]), .debug_wb_rf_wnum(dwn[2]), .debug_wb_rf_wdata(dwd[2]));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which channel may hand over an instruction, from the arbitration rules.
    function automatic logic [1:0] exp_ready(input bit rr, input logic [1:0] v, input logic fl, input int ptr);
        logic [1:0] r;
        r = 2'b00;
        if (fl) return r;
        if (!rr) begin
            r[0] = 1'b1;
            r[1] = !v[0];
            return r;
        end
        for (int k = 0; k < 2; k++) begin
            int c;
            c = (ptr + k) % 2;
            if (v[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        r[ptr] = 1'b1;
        return r;
    endfunction

    function automatic logic [37:0] exp_rf(input bit vld, input inst_t in);
        return {vld && in.we && (in.dest != 5'd0), in.dest, in.res};
    endfunction

    bit          started = 0;
    bit          m_valid [3];
    inst_t       m_inst  [3];
    int unsigned m_cnt   [3];
    int          m_ptr;
    logic [1:0]  m_r, m_x;

    always @(posedge clk) begin
        if (reset) begin
            started = 1;
            m_ptr   = 0;
            for (int d = 0; d < 3; d++) begin
                m_valid[d] = 0;
                m_inst[d]  = '0;
                m_cnt[d]   = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (m_valid[d]) m_cnt[d]++;
                m_r = exp_ready(d == 1, s_valid, flush, m_ptr);
                m_x = s_valid & m_r;
                if (m_x != 2'b00) begin
                    m_inst[d]  = m_x[0] ? chan[0] : chan[1];
                    m_valid[d] = 1;
                    if (d == 1) m_ptr = m_x[0] ? 1 : 0;
                end else begin
                    m_valid[d] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 3; d++) begin
                logic [37:0] erf;
                erf = exp_rf(m_valid[d], m_inst[d]);
                check($sformatf("ready[%0d]", d), 64'(rdy[d]), 64'(exp_ready(d == 1, s_valid, flush, m_ptr)));
                check($sformatf("rf_valid[%0d]", d), 64'(rfv[d]), 64'(m_valid[d]));
                check($sformatf("rf_bus[%0d]", d), 64'(rfb[d]), 64'(erf));
                check($sformatf("retire_cnt[%0d]", d), 64'(cnt[d]),
                      (d == 2) ? 64'(m_cnt[d] & 32'hF) : 64'(m_cnt[d]));
`ifdef WB_TRACE_EN
                check($sformatf("dbg_pc[%0d]", d), 64'(dpc[d]), 64'(m_inst[d].pc));
                check($sformatf("dbg_we[%0d]", d), 64'(dwe[d]), 64'({4{erf[37]}}));
                check($sformatf("dbg_wnum[%0d]", d), 64'(dwn[d]), 64'(m_inst[d].dest));
                check($sformatf("dbg_wdata[%0d]", d), 64'(dwd[d]), 64'(m_inst[d].res));
`else
                check($sformatf("dbg_all[%0d]", d), 64'({dpc[d], dwe[d], dwn[d]} | 64'(dwd[d])), 64'd0);
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    function automatic inst_t mk(input logic we, input logic [4:0] dst, input logic [31:0] res, input logic [31:0] pc);
        inst_t t;
        t.we = we; t.dest = dst; t.res = res; t.pc = pc;
        return t;
    endfunction

    initial begin
        reset = 1; s_valid = 2'b00; flush = 0;
        chan[0] = '0; chan[1] = '0;
        cyc(); cyc();
        reset = 0;
        at_neg();
        check("rst_rf_valid", 64'(rfv[0]), 64'd0);
        check("rst_rf_bus", 64'(rfb[0]), 64'd0);
        check("rst_cnt", 64'(cnt[0]), 64'd0);
        check("rst_dbg_pc", 64'(dpc[0]), 64'd0);

        // single write from source 0
        cyc();
        chan[0] = mk(1, 5'd5, 32'h1234, 32'h1c000000);
        s_valid = 2'b01;
        at_neg();
        check("single_ready_fp", 64'(rdy[0]), 64'(2'b01));
        cyc();
        s_valid = 2'b00;
        at_neg();
        check("single_rf_bus", 64'(rfb[0]), 64'({1'b1, 5'd5, 32'h1234}));
`ifdef WB_TRACE_EN
        check("single_dbg_pc", 64'(dpc[0]), 64'h1c000000);
`else
        check("single_dbg_pc", 64'(dpc[0]), 64'd0);
`endif
        check("single_cnt_before", 64'(cnt[0]), 64'd0);
        cyc();
        at_neg();
        check("single_cnt_after", 64'(cnt[0]), 64'd1);

        // fixed-priority contention
        cyc();
        chan[1] = mk(1, 5'd9, 32'hBBBB0000, 32'h1c000100);
        for (int k = 0; k < 3; k++) begin
            chan[0] = mk(1, 5'd3, 32'hAAAA0000 + k, 32'h1c000200 + 4*k);
            s_valid = 2'b11;
            at_neg();
            check("fp_contend_ready", 64'(rdy[0]), 64'(2'b01));
            cyc();
            at_neg();
            check("fp_contend_wb", 64'(rfb[0]), 64'({1'b1, 5'd3, 32'hAAAA0000 + k}));
            cyc();
            if (k < 2) #0;
        end
        s_valid = 2'b10;
        at_neg();
        check("fp_src1_ready", 64'(rdy[0]), 64'(2'b11));
        cyc();
        s_valid = 2'b00;
        at_neg();
        check("fp_src1_wb", 64'(rfb[0]), 64'({1'b1, 5'd9, 32'hBBBB0000}));
        cyc();

        // round-robin contention from a known pointer
        reset = 1;
        cyc();
        reset = 0;
        s_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check("rr_alternate", 64'(rdy[1]), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            cyc();
        end
        s_valid = 2'b00;
        at_neg();
        check("rr_cnt_every_cycle", 64'(cnt[1]), 64'd3);
        check("rr_last_is_src1", 64'(rfb[1]), 64'({1'b1, 5'd9, 32'hBBBB0000}));
        cyc();

        // r0 and non-writing ops
        chan[0] = mk(1, 5'd0, 32'hDEAD0000, 32'h1c000300);
        s_valid = 2'b01;
        cyc();
        chan[0] = mk(0, 5'd7, 32'hBEEF0000, 32'h1c000304);
        at_neg();
        check("r0_suppressed", 64'(rfb[0][37]), 64'd0);
        check("r0_valid", 64'(rfv[0]), 64'd1);
        cyc();
        s_valid = 2'b00;
        at_neg();
        check("nowe_suppressed", 64'(rfb[0][37]), 64'd0);
        check("nowe_dest", 64'(rfb[0][36:32]), 64'd7);
        cyc();

        // flush with an instruction already in WB
        chan[0] = mk(1, 5'd11, 32'h0000F00D, 32'h1c000400);
        s_valid = 2'b01;
        cyc();
        flush = 1;
        chan[0] = mk(1, 5'd12, 32'h0000CAFE, 32'h1c000404);
        at_neg();
        check("flush_ready", 64'(rdy[0]), 64'd0);
        check("flush_prev_writes", 64'(rfb[0]), 64'({1'b1, 5'd11, 32'h0000F00D}));
        cyc();
        at_neg();
        check("flush_next_invalid", 64'(rfv[0]), 64'd0);
        cyc();
        flush = 0;
        s_valid = 2'b00;

        // reset while WB is occupied
        chan[0] = mk(1, 5'd13, 32'h00001313, 32'h1c000500);
        s_valid = 2'b01;
        cyc();
        s_valid = 2'b00;
        reset = 1;
        at_neg();
        check("midrst_before", 64'(rfv[0]), 64'd1);
        cyc();
        at_neg();
        check("midrst_valid", 64'(rfv[0]), 64'd0);
        check("midrst_cnt", 64'(cnt[0]), 64'd0);
        check("midrst_bus", 64'(rfb[0]), 64'd0);
        cyc();
        reset = 0;

        // 17 retirements on the 4-bit counter
        for (int k = 0; k < 17; k++) begin
            chan[0] = mk(1, 5'd1 + 5'(k % 30), 32'h100 + k, 32'h1c001000 + 4*k);
            s_valid = 2'b01;
            cyc();
        end
        s_valid = 2'b00;
        cyc();
        at_neg();
        check("wrap_cnt4", 64'(cnt[2]), 64'd1);
        check("wrap_cnt32", 64'(cnt[0]), 64'd17);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
